// File: rtl/debounce_pkg.sv
// Shared defaults and elaboration helpers for the push-button debouncer.
package debounce_pkg;

    localparam int unsigned DEBOUNCE_SYNC_STAGES   = 2;
    localparam int unsigned DEBOUNCE_STABLE_CYCLES = 4;
    localparam int unsigned DEBOUNCE_CNT_W         = 8;

    // Smallest counter width w with 2^w > stable_cycles.
    function automatic int unsigned min_cnt_w(input int unsigned stable_cycles);
        int unsigned w;
        w = 32;
        for (int i = 31; i >= 1; i--) begin
            if ((longint'(1) << i) > longint'(stable_cycles)) begin
                w = i;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// N-flop synchroniser bringing an asynchronous level into the clk domain.
module debounce_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // NOTE: flops are written with <= so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debounce.sv
// Push-button debouncer: synchroniser, stability counter and press pulse generator.
module debounce
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEBOUNCE_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES,
    parameter int unsigned CNT_W         = DEBOUNCE_CNT_W
) (
    input  logic btn,
    input  logic clk,
    output logic btn_out,
    output logic single_pulse_out,
    input  logic rst
);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("debounce: SYNC_STAGES must be at least 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
        $error("debounce: STABLE_CYCLES must be at least 1");
    end
    if (CNT_W < min_cnt_w(STABLE_CYCLES)) begin : g_bad_cnt_w
        $error("debounce: CNT_W too narrow for STABLE_CYCLES");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_out_q, btn_out_d;
    logic             pulse_q, pulse_d;

    debounce_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn),
        .q   (s)
    );

    // A sample matching the current level discards progress, so bounce restarts the count.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        cnt_d     = '0;
        btn_out_d = btn_out_q;
        pulse_d   = 1'b0;
        if (s != btn_out_q) begin
            if (cnt_q == CNT_LAST) begin
                btn_out_d = s;
                pulse_d   = s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            btn_out_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            btn_out_q <= btn_out_d;
            pulse_q   <= pulse_d;
        end
    end

    assign btn_out          = btn_out_q;
    assign single_pulse_out = pulse_q;

endmodule

// File: tb/tb_debounce.sv
// Self-checking bench for debounce: window-based reference model feeding a scoreboard plus directed latency checks.
module tb_debounce;
    import debounce_pkg::*;

    localparam int unsigned ST = DEBOUNCE_STABLE_CYCLES;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic btn_out;
    logic single_pulse_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pulse  = 0;
    int edge_n   = 0;
    logic seen_high = 1'b0;

    debounce dut (
        .btn              (btn),
        .clk              (clk),
        .btn_out          (btn_out),
        .single_pulse_out (single_pulse_out),
        .rst              (rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: two-flop sync delay, then the level flips once the last ST synchronised
    // samples since reset all disagree with the current level.
    logic [1:0]    m_sync;
    logic [ST-1:0] m_win;
    int            m_hist;
    logic          m_out;
    logic [1:0]    sb[$];

    always @(posedge clk or posedge rst) begin
        logic          s_now;
        logic [ST-1:0] win_next;
        int            hist_next;
        logic          out_next;
        logic          pulse_exp;
        if (rst) begin
            sb.delete();
            m_sync <= '0;
            m_win  <= '0;
            m_hist <= 0;
            m_out  <= 1'b0;
        end else begin
            s_now     = m_sync[1];
            win_next  = {m_win[ST-2:0], s_now};
            hist_next = (m_hist < int'(ST)) ? m_hist + 1 : m_hist;
            out_next  = m_out;
            pulse_exp = 1'b0;
            if (hist_next >= int'(ST) && win_next == {ST{~m_out}}) begin
                out_next  = ~m_out;
                pulse_exp = ~m_out;
            end
            sb.push_back({out_next, pulse_exp});
            m_sync <= {m_sync[0], btn};
            m_win  <= win_next;
            m_hist <= hist_next;
            m_out  <= out_next;
        end
    end

    always @(posedge clk) edge_n++;

    always @(negedge clk) begin
        logic [1:0] exp;
        if (single_pulse_out === 1'b1) n_pulse++;
        if (btn_out === 1'b1) seen_high = 1'b1;
        if (rst === 1'b1) begin
            check("rst_out", 32'(btn_out), 32'd0);
            check("rst_pulse", 32'(single_pulse_out), 32'd0);
        end else begin
            exp = (sb.size() > 0) ? sb.pop_front() : 2'b00;
            check("sb_out", 32'(btn_out), 32'(exp[1]));
            check("sb_pulse", 32'(single_pulse_out), 32'(exp[0]));
        end
    end

    // One clock of stimulus: v1 mid-high phase, v2 mid-low phase (v2 is what the next edge samples).
    task automatic step(input logic v1, input logic v2);
        @(posedge clk);
        #2 btn = v1;
        #5 btn = v2;
    endtask

    task automatic hold(input logic v, input int n);
        repeat (n) step(v, v);
    endtask

    // Edges from the first sampling edge of the current btn level to the btn_out change; -1 on timeout.
    task automatic measure(input logic level, output int delay);
        int k;
        k = edge_n + 1;
        delay = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (btn_out === level) begin
                delay = edge_n - k;
                break;
            end
        end
    endtask

    initial begin
        int d;
        int p0;
        btn = 1'b0;
        rst = 1'b1;

        // Reset with btn toggling
        for (int i = 0; i < 4; i++) step(i[0], ~i[0]);
        check("rst_hold_out", 32'(btn_out), 32'd0);
        check("rst_hold_pulse", 32'(single_pulse_out), 32'd0);
        @(negedge clk);
        btn = 1'b0;
        #1 rst = 1'b0;
        hold(1'b0, 6);
        check("idle_out", 32'(btn_out), 32'd0);

        // Clean press
        p0 = n_pulse;
        step(1'b0, 1'b1);
        fork
            hold(1'b1, 10);
            measure(1'b1, d);
        join
        check("press_latency", 32'(d), 32'd5);
        check("press_pulses", 32'(n_pulse - p0), 32'd1);
        hold(1'b0, 10);
        check("press_released", 32'(btn_out), 32'd0);

        // Fast bounce, then back to 0
        p0 = n_pulse;
        seen_high = 1'b0;
        for (int i = 0; i < 5; i++) step(i[0], ~i[0]);
        hold(1'b0, 8);
        check("bounce_out_seen", 32'(seen_high), 32'd0);
        check("bounce_pulses", 32'(n_pulse - p0), 32'd0);

        // Bounce then settle high
        p0 = n_pulse;
        for (int i = 1; i <= 4; i++) step(i[0], i[0]);
        step(1'b1, 1'b1);
        fork
            hold(1'b1, 9);
            measure(1'b1, d);
        join
        check("settle_latency", 32'(d), 32'd5);
        check("settle_pulses", 32'(n_pulse - p0), 32'd1);
        hold(1'b1, 10);
        check("held_pulses", 32'(n_pulse - p0), 32'd1);
        check("held_cnt", 32'(dut.cnt_q), 32'd0);
        check("held_out", 32'(btn_out), 32'd1);

        // Release with bounce
        p0 = n_pulse;
        for (int i = 0; i < 6; i++) step(i[0], i[0]);
        step(1'b0, 1'b0);
        fork
            hold(1'b0, 24);
            measure(1'b0, d);
        join
        check("release_latency", 32'(d), 32'd5);
        check("release_pulses", 32'(n_pulse - p0), 32'd0);

        // Reset mid-count, then fresh press out of reset
        p0 = n_pulse;
        step(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dut.cnt_q == 3) break;
        end
        check("mid_cnt", 32'(dut.cnt_q), 32'd3);
        #1 rst = 1'b1;
        #1;
        check("async_rst_out", 32'(btn_out), 32'd0);
        check("async_rst_pulse", 32'(single_pulse_out), 32'd0);
        check("async_rst_cnt", 32'(dut.cnt_q), 32'd0);
        hold(1'b1, 2);
        @(negedge clk);
        #1 rst = 1'b0;
        fork
            hold(1'b1, 10);
            measure(1'b1, d);
        join
        check("post_rst_latency", 32'(d), 32'd5);
        check("post_rst_pulses", 32'(n_pulse - p0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
